sampler: RTL and testbench

Random value proposer for the probabilistic-search engine. On each enabled clock it draws pseudo-random bits from an internal seeded 16-bit LFSR. It maps them into the signed range [in_from, in_to] according to the chosen segment type (uniform, exponential-up, exponential-down) and registers the result. Downstream MCMC acceptance logic consumes out_proposed_value as the next candidate value of the variable being updated.

---
 rtl/sampler_if.sv | 30 +++
 rtl/sampler.sv | 71 +++++++
 tb/tb_sampler.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sampler_if.sv
// rtl/sampler_if.sv - control, range and result signals of the sampler
interface sampler_if;
  logic              in_enable;
  logic [7:0]        in_seed;
  logic signed [7:0] in_from;
  logic signed [7:0] in_to;
  logic [1:0]        in_chosen_segment_type;
  logic signed [7:0] in_chosen_segment_weight;
  logic signed [7:0] out_proposed_value;

  modport master (
    output in_enable,
    output in_seed,
    output in_from,
    output in_to,
    output in_chosen_segment_type,
    output in_chosen_segment_weight,
    input  out_proposed_value
  );

  modport slave (
    input  in_enable,
    input  in_seed,
    input  in_from,
    input  in_to,
    input  in_chosen_segment_type,
    input  in_chosen_segment_weight,
    output out_proposed_value
  );
endinterface

// File: rtl/sampler.sv
// rtl/sampler.sv - seeded LFSR random proposer shaped into a signed range
module sampler (
  input  logic      in_clock,
  input  logic      in_reset,
  sampler_if.slave  bus
);

  localparam logic [1:0] SEG_EXPDOWN = 2'd1;
  localparam logic [1:0] SEG_EXPUP   = 2'd2;

  logic [15:0]       lfsr;
  logic [15:0]       lfsr_next;
  logic [15:0]       seed_state;
  logic [7:0]        r1;
  logic [7:0]        r2;
  logic signed [8:0] span;
  logic              span_pos;
  logic [7:0]        span_u;
  logic [8:0]        modulus;
  logic [7:0]        u;
  logic [7:0]        v;
  logic [7:0]        divisor;
  logic [15:0]       product;
  logic [7:0]        quotient;
  logic [7:0]        offset;
  logic signed [7:0] result;
  logic signed [7:0] out_q;

  // Seed 0 still yields a nonzero state thanks to the fixed low byte.
  assign seed_state = (bus.in_seed == 8'd0) ? 16'h00A5 : {bus.in_seed, 8'hA5};
  assign lfsr_next  = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  assign r1 = lfsr[15:8];
  assign r2 = lfsr[7:0];

  always_comb begin
    span     = {bus.in_to[7], bus.in_to} - {bus.in_from[7], bus.in_from};
    span_pos = (span > 9'sd0);
    span_u   = span[7:0];
    modulus  = {1'b0, span_u} + 9'd1;
    u        = 8'({1'b0, r1} % modulus);
    v        = 8'({1'b0, r2} % modulus);
    // Divisor is only meaningful for a positive span; guard against /0.
    divisor  = span_pos ? span_u : 8'd1;
    product  = {8'd0, u} * {8'd0, v};
    quotient = 8'(product / {8'd0, divisor});
    offset   = u;
    if (!span_pos) begin
      offset = 8'd0;
    end else if (bus.in_chosen_segment_weight != 8'sd0) begin
      case (bus.in_chosen_segment_type)
        SEG_EXPDOWN: offset = quotient;
        SEG_EXPUP:   offset = span_u - quotient;
        default:     offset = u;
      endcase
    end
    result = bus.in_from + offset;
  end

  always_ff @(posedge in_clock) begin
    if (in_reset) begin
      lfsr  <= seed_state;
      out_q <= '0;
    end else if (bus.in_enable) begin
      lfsr  <= lfsr_next;
      out_q <= result;
    end
  end

  assign bus.out_proposed_value = out_q;

endmodule

// File: tb/tb_sampler.sv
// tb/tb_sampler.sv - scoreboard bench for sampler with a reference model
module tb_sampler;

  logic clk = 1'b0;
  logic in_reset = 1'b0;
  sampler_if bus ();

  sampler dut (
    .in_clock (clk),
    .in_reset (in_reset),
    .bus      (bus)
  );

  initial forever #50 clk = ~clk;

  typedef struct {
    logic signed [7:0] val;
    int                tag;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  logic [15:0]       m_state = 16'h0;
  logic signed [7:0] m_out = 8'sd0;
  bit                m_valid = 1'b0;

  int st_sum, st_n, st_min, st_max;
  int seq_a[$];
  int seq_b[$];

  function automatic logic signed [7:0] ref_value(logic [15:0] s, logic signed [7:0] from,
      logic signed [7:0] to, logic [1:0] typ, logic signed [7:0] wt);
    int f, t, span, off, u, v;
    logic [7:0] hi, lo;
    f = from;
    t = to;
    hi = s[15:8];
    lo = s[7:0];
    span = t - f;
    if (span <= 0) begin
      off = 0;
    end else begin
      u = int'(hi) % (span + 1);
      v = int'(lo) % (span + 1);
      if (typ == 2'd1 && wt != 0) off = (u * v) / span;
      else if (typ == 2'd2 && wt != 0) off = span - (u * v) / span;
      else off = u;
    end
    return 8'(f + off);
  endfunction

  function automatic logic [15:0] ref_step(logic [15:0] s);
    return {s[14:0], ^(s & 16'hB400)};
  endfunction

  task automatic cyc(bit rst, logic [7:0] seed, bit en, logic signed [7:0] from,
      logic signed [7:0] to, logic [1:0] typ, logic signed [7:0] wt, int tag);
    @(negedge clk);
    in_reset = rst;
    bus.in_enable = en;
    bus.in_seed = seed;
    bus.in_from = from;
    bus.in_to = to;
    bus.in_chosen_segment_type = typ;
    bus.in_chosen_segment_weight = wt;
    if (rst) begin
      m_state = (seed == 8'd0) ? 16'h00A5 : {seed, 8'hA5};
      m_out = 8'sd0;
      m_valid = 1'b1;
    end else if (en) begin
      m_out = ref_value(m_state, from, to, typ, wt);
      m_state = ref_step(m_state);
    end
    if (m_valid) sb.push_back('{m_out, tag});
  endtask

  task automatic chk(string name, bit ok, int act, int req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (sb.size() > 0 && k < 10) begin
      @(posedge clk);
      #2;
      k++;
    end
    chk("drain", sb.size() == 0, sb.size(), 0);
  endtask

  task automatic clear_stats();
    st_sum = 0;
    st_n = 0;
    st_min = 1000;
    st_max = -1000;
  endtask

  initial begin : monitor
    exp_t e;
    int a;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        a = bus.out_proposed_value;
        checks++;
        if (bus.out_proposed_value !== e.val) begin
          failures++;
          $display("FAIL out_proposed_value at %0t: got %0d, required %0d", $time, a, e.val);
        end
        case (e.tag)
          1: begin
            st_sum += a;
            st_n++;
            if (a < st_min) st_min = a;
            if (a > st_max) st_max = a;
          end
          2: seq_a.push_back(a);
          3: seq_b.push_back(a);
          default: ;
        endcase
      end
    end
  end

  initial begin : watchdog
    #(100 * 60000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    logic signed [7:0] rf[20];
    logic signed [7:0] rt[20];
    logic [1:0]        rty[20];
    logic signed [7:0] rw[20];
    int same;

    bus.in_enable = 1'b0;
    bus.in_seed = 8'd0;
    bus.in_from = 8'sd0;
    bus.in_to = 8'sd0;
    bus.in_chosen_segment_type = 2'd0;
    bus.in_chosen_segment_weight = 8'sd0;
    clear_stats();

    // Reset state and first draw
    cyc(1, 8'd4, 1, 0, 50, 2'd1, 7, 0);
    drain();
    chk("reset_state", dut.lfsr == 16'h04A5, dut.lfsr, 16'h04A5);
    chk("reset_out", bus.out_proposed_value == 8'sd0, bus.out_proposed_value, 0);
    cyc(0, 8'd4, 1, 0, 50, 2'd1, 7, 0);
    drain();
    chk("first_draw", bus.out_proposed_value == 8'sd0, bus.out_proposed_value, 0);

    // Enable toggling: hold cycles are covered by the scoreboard
    clear_stats();
    for (int i = 0; i < 20; i++) cyc(0, 8'd4, (i % 2) == 0, 0, 50, 2'd1, 7, 1);
    drain();
    chk("toggle_min", st_min >= 0, st_min, 0);
    chk("toggle_max", st_max <= 50, st_max, 50);

    clear_stats();
    for (int i = 0; i < 1000; i++)
      cyc(0, 8'd4, 1, -20, 20, (i % 2) ? 2'd3 : 2'd0, 8'($urandom), 1);
    drain();
    chk("uniform_min_reached", st_min == -20, st_min, -20);
    chk("uniform_max_reached", st_max == 20, st_max, 20);

    clear_stats();
    for (int i = 0; i < 1000; i++) cyc(0, 8'd4, 1, -20, 20, 2'd1, 7, 1);
    drain();
    chk("expdown_mean_neg", st_sum < 0, st_sum, 0);

    clear_stats();
    for (int i = 0; i < 1000; i++) cyc(0, 8'd4, 1, -20, 20, 2'd2, 7, 1);
    drain();
    chk("expup_mean_pos", st_sum > 0, st_sum, 0);

    clear_stats();
    for (int i = 0; i < 1000; i++) cyc(0, 8'd4, 1, -20, 20, 2'(1 + (i % 2)), 0, 1);
    drain();
    chk("weight0_mean", st_sum <= 5 * st_n && st_sum >= -5 * st_n, st_sum, 0);

    clear_stats();
    for (int i = 0; i < 50; i++) cyc(0, 8'd4, 1, -5, -5, 2'($urandom), 8'($urandom), 1);
    drain();
    chk("equal_range_min", st_min == -5, st_min, -5);
    chk("equal_range_max", st_max == -5, st_max, -5);

    clear_stats();
    for (int i = 0; i < 50; i++) cyc(0, 8'd4, 1, 10, 3, 2'($urandom), 8'($urandom), 1);
    drain();
    chk("inverted_range_min", st_min == 10, st_min, 10);
    chk("inverted_range_max", st_max == 10, st_max, 10);

    cyc(1, 8'd0, 1, 0, 50, 2'd3, 0, 0);
    drain();
    chk("seed0_state", dut.lfsr == 16'h00A5, dut.lfsr, 16'h00A5);
    clear_stats();
    for (int i = 0; i < 50; i++) cyc(0, 8'd0, 1, 0, 50, 2'd3, 0, 1);
    drain();
    chk("seed0_varies", st_min != st_max, st_max, st_min);

    // Reseed mid-run must replay the same sequence
    for (int i = 0; i < 20; i++) begin
      rf[i] = 8'($urandom_range(0, 60)) - 8'sd30;
      rt[i] = 8'($urandom_range(0, 60)) - 8'sd20;
      rty[i] = 2'($urandom);
      rw[i] = 8'($urandom_range(0, 3));
    end
    cyc(1, 8'd77, 1, 0, 0, 2'd0, 0, 0);
    for (int i = 0; i < 20; i++) cyc(0, 8'd77, 1, rf[i], rt[i], rty[i], rw[i], 2);
    for (int i = 0; i < 5; i++) cyc(0, 8'd77, 1, -100, 100, 2'd3, 0, 0);
    cyc(1, 8'd77, 1, 0, 0, 2'd0, 0, 0);
    for (int i = 0; i < 20; i++) cyc(0, 8'd77, 1, rf[i], rt[i], rty[i], rw[i], 3);
    drain();
    chk("reseed_len", seq_a.size() == 20 && seq_b.size() == 20, seq_b.size(), 20);
    same = 0;
    for (int i = 0; i < 20 && i < seq_a.size() && i < seq_b.size(); i++)
      if (seq_a[i] == seq_b[i]) same++;
    chk("reseed_repeat", same == 20, same, 20);

    // Fully random traffic, occasional reset
    for (int i = 0; i < 600; i++)
      cyc($urandom_range(0, 99) < 3, 8'($urandom), $urandom_range(0, 3) != 0,
          8'($urandom), 8'($urandom), 2'($urandom), 8'($urandom_range(0, 2)), 0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
